data_mem_responder: RTL and testbench
=====================================

DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

Interface
REQ-001 SHALL have parameter DATA_W, default 32, data word width in bits.
REQ-002 SHALL have parameter ADDR_W, default 12, byte-address width; array depth is 2^(ADDR_W-2) words.
REQ-003 SHALL have parameter LATENCY, default 2, cycles from request acceptance to response; legal range 1..15.
REQ-004 SHALL have port clk_i  input  1  single clock; all state changes on rising edge.
REQ-005 SHALL have port reset_i  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port mem_read_i  input  1  read request from pipeline control.
REQ-007 SHALL have port mem_write_i  input  1  write request from pipeline control.
REQ-008 SHALL have port addr_i  input  ADDR_W  byte address of request.
REQ-009 SHALL have port wdata_i  input  DATA_W  store data.
REQ-010 SHALL have port ready_o  output  1  high when a new request can be accepted.
REQ-011 SHALL have port stall_o  output  1  pipeline hold while a request is pending or in flight.
REQ-012 SHALL have port resp_valid_o  output  1  one-cycle pulse marking completion.
REQ-013 SHALL have port rdata_o  output  DATA_W  load data.
REQ-014 SHALL have port err_o  output  1  request error, qualified by resp_valid_o.

Function
REQ-015 SHALL implement FSM states IDLE, WAIT, DONE; ready_o high only in IDLE.
REQ-016 SHALL accept a request when (mem_read_i or mem_write_i) and ready_o, registering opcode, addr_i, wdata_i.
REQ-017 SHALL transition IDLE->DONE on acceptance when LATENCY=1, else IDLE->WAIT with counter loaded to LATENCY-2.
REQ-018 SHALL stay in WAIT decrementing the counter each cycle, moving to DONE when the counter is 0.
REQ-019 SHALL assert resp_valid_o for exactly one cycle in DONE, then return to IDLE; back-to-back accept on the cycle after DONE.
REQ-020 SHALL give a response LATENCY cycles after the acceptance edge.
REQ-021 SHALL commit writes to the array at the DONE edge, word index addr[ADDR_W-1:2].
REQ-022 SHALL update rdata_o in DONE for reads only; rdata_o holds its value otherwise.
REQ-023 SHALL drive stall_o = (mem_read_i or mem_write_i) and not IDLE, or state is WAIT.
REQ-024 SHALL ignore request inputs outside IDLE; inputs change without effect on in-flight access.
REQ-025 SHALL, with both mem_read_i and mem_write_i high at acceptance, treat as per Configuration.

Reset
REQ-026 SHALL on reset_i low force state IDLE, counter 0, ready_o 1, stall_o 0, resp_valid_o 0, rdata_o 0, err_o 0.
REQ-027 SHALL drop any in-flight request on reset mid-operation; a pending write is not committed.
REQ-028 SHALL leave array contents unaffected by reset.

Configuration
REQ-029 SHALL use macro DMEM_ERR_CHECK_EN.
REQ-030 With DMEM_ERR_CHECK_EN defined: misaligned addr (addr[1:0]!=0) or simultaneous read+write SHALL complete with err_o=1, no array write, rdata_o unchanged.
REQ-031 Without DMEM_ERR_CHECK_EN: err_o SHALL be tied 0, addr[1:0] ignored, simultaneous read+write performs the write only.

Structure
REQ-032 SHALL place FSM state enum and default parameter constants in shared package aurora_pkg.
REQ-033 SHALL place storage in sub-module dmem_array (synchronous write, registered read port).

Verification
REQ-034 Reset: reset_i low mid-WAIT -> next edge ready_o=1, resp_valid_o=0, rdata_o=0; later read of that address shows old data.
REQ-035 Write then read, LATENCY=2: write 0xDEADBEEF to 0x010, then read 0x010 -> resp_valid_o 2 cycles after each accept, rdata_o=0xDEADBEEF.
REQ-036 LATENCY=1 back-to-back reads of 0x000 and 0x004 -> responses on consecutive alternate cycles, stall_o high only while busy.
REQ-037 Request held high across WAIT -> exactly one access and one resp_valid_o pulse per acceptance.
REQ-038 DMEM_ERR_CHECK_EN defined: read of 0x013 -> err_o=1 with resp_valid_o, rdata_o unchanged; undefined: same read returns word at 0x010, err_o=0.
REQ-039 Simultaneous read+write to 0x020 with 0x12345678 -> macro on: err_o=1, word unchanged; macro off: word becomes 0x12345678.

Source files
------------

// File: rtl/aurora_pkg.sv
// Shared types and default sizing for the data memory responder.
// Holds the responder FSM state encoding and parameter defaults.
package aurora_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam int DEF_DATA_W  = 32;
  localparam int DEF_ADDR_W  = 12;
  localparam int DEF_LATENCY = 2;
  localparam int CNT_W       = 4;

endpackage

// File: rtl/dmem_array.sv
// Word-addressed storage: synchronous write, registered read port.
// Contents are never reset.
module dmem_array
  import aurora_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int IDX_W  = DEF_ADDR_W - 2
) (
  input  logic              clk_i,
  input  logic              we_i,
  input  logic [IDX_W-1:0]  waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic              re_i,
  input  logic [IDX_W-1:0]  raddr_i,
  output logic [DATA_W-1:0] rdata_o
);

  logic [DATA_W-1:0] mem_q [2**IDX_W];
  logic [DATA_W-1:0] rdata_q;

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
    if (re_i) begin
      rdata_q <= mem_q[raddr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/data_mem_responder.sv
// Fixed-latency data memory responder with IDLE/WAIT/DONE handshake.
// Define DMEM_ERR_CHECK_EN to flag misaligned and read+write requests.
module data_mem_responder
  import aurora_pkg::*;
#(
  parameter int DATA_W  = DEF_DATA_W,
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int LATENCY = DEF_LATENCY
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              mem_read_i,
  input  logic              mem_write_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [DATA_W-1:0] wdata_i,
  output logic              ready_o,
  output logic              stall_o,
  output logic              resp_valid_o,
  output logic [DATA_W-1:0] rdata_o,
  output logic              err_o
);

  localparam int IDX_W = ADDR_W - 2;
  localparam logic [CNT_W-1:0] CNT_INIT =
    (LATENCY > 1) ? CNT_W'(LATENCY - 2) : '0;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              rd_q, rd_d;
  logic              wr_q, wr_d;
  logic              err_q, err_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;

  logic              req;
  logic              req_rd;
  logic              req_wr;
  logic              req_err;
  logic              arr_we;
  logic              arr_re;
  logic [IDX_W-1:0]  arr_raddr;
  logic [DATA_W-1:0] arr_rdata;
  logic              rd_ok;

  assign req = mem_read_i | mem_write_i;

`ifdef DMEM_ERR_CHECK_EN
  assign req_err = (addr_i[1:0] != 2'b00)
                 | (mem_read_i & mem_write_i);
  assign req_rd  = mem_read_i;
  assign req_wr  = mem_write_i;
`else
  logic unused_addr_lsb;
  assign unused_addr_lsb = ^addr_i[1:0];
  assign req_err = 1'b0;
  // Read+write collapses to a plain write
  assign req_rd  = mem_read_i & ~mem_write_i;
  assign req_wr  = mem_write_i;
`endif

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    rd_d      = rd_q;
    wr_d      = wr_q;
    err_d     = err_q;
    idx_d     = idx_q;
    wdata_d   = wdata_q;
    rdata_d   = rdata_q;
    arr_re    = 1'b0;
    arr_raddr = idx_q;
    unique case (state_q)
      IDLE: begin
        if (req) begin
          rd_d    = req_rd;
          wr_d    = req_wr;
          err_d   = req_err;
          idx_d   = addr_i[ADDR_W-1:2];
          wdata_d = wdata_i;
          if (LATENCY == 1) begin
            state_d   = DONE;
            arr_re    = 1'b1;
            arr_raddr = addr_i[ADDR_W-1:2];
          end else begin
            state_d = WAIT;
            cnt_d   = CNT_INIT;
          end
        end
      end
      WAIT: begin
        if (cnt_q == '0) begin
          state_d = DONE;
          arr_re  = 1'b1;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      DONE: begin
        state_d = IDLE;
        if (rd_ok) begin
          rdata_d = arr_rdata;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
      err_q   <= 1'b0;
      idx_q   <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      err_q   <= err_d;
      idx_q   <= idx_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
    end
  end

  // Write lands on the edge that leaves DONE
  assign arr_we = (state_q == DONE) & wr_q & ~err_q;
  assign rd_ok  = (state_q == DONE) & rd_q & ~err_q;

  dmem_array #(
    .DATA_W (DATA_W),
    .IDX_W  (IDX_W)
  ) u_array (
    .clk_i   (clk_i),
    .we_i    (arr_we),
    .waddr_i (idx_q),
    .wdata_i (wdata_q),
    .re_i    (arr_re),
    .raddr_i (arr_raddr),
    .rdata_o (arr_rdata)
  );

  assign ready_o      = (state_q == IDLE);
  assign resp_valid_o = (state_q == DONE);
  assign stall_o      = (req & (state_q != IDLE))
                      | (state_q == WAIT);
  assign rdata_o      = rd_ok ? arr_rdata : rdata_q;

`ifdef DMEM_ERR_CHECK_EN
  assign err_o = (state_q == DONE) & err_q;
`else
  assign err_o = 1'b0;
`endif

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench: LATENCY=2 and LATENCY=1 responder instances.
// Expectations follow DMEM_ERR_CHECK_EN when it is defined.
module tb_data_mem_responder;

`ifdef DMEM_ERR_CHECK_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset_n;

  logic        rd_a, wr_a;
  logic [11:0] addr_a;
  logic [31:0] wdata_a;
  logic        ready_a, stall_a, resp_a, err_a;
  logic [31:0] rdata_a;

  logic        rd_b, wr_b;
  logic [11:0] addr_b;
  logic [31:0] wdata_b;
  logic        ready_b, stall_b, resp_b, err_b;
  logic [31:0] rdata_b;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  data_mem_responder #(
    .DATA_W  (32),
    .ADDR_W  (12),
    .LATENCY (2)
  ) u_dut_a (
    .clk_i        (clk),
    .reset_i      (reset_n),
    .mem_read_i   (rd_a),
    .mem_write_i  (wr_a),
    .addr_i       (addr_a),
    .wdata_i      (wdata_a),
    .ready_o      (ready_a),
    .stall_o      (stall_a),
    .resp_valid_o (resp_a),
    .rdata_o      (rdata_a),
    .err_o        (err_a)
  );

  data_mem_responder #(
    .DATA_W  (32),
    .ADDR_W  (12),
    .LATENCY (1)
  ) u_dut_b (
    .clk_i        (clk),
    .reset_i      (reset_n),
    .mem_read_i   (rd_b),
    .mem_write_i  (wr_b),
    .addr_i       (addr_b),
    .wdata_i      (wdata_b),
    .ready_o      (ready_b),
    .stall_o      (stall_b),
    .resp_valid_o (resp_b),
    .rdata_o      (rdata_b),
    .err_o        (err_b)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  initial begin
    reset_n = 1'b0;
    rd_a = 0; wr_a = 0; addr_a = '0; wdata_a = '0;
    rd_b = 0; wr_b = 0; addr_b = '0; wdata_b = '0;
    tick();
    tick();
    check("rst_ready", ready_a, 1);
    check("rst_stall", stall_a, 0);
    check("rst_resp", resp_a, 0);
    check("rst_rdata", rdata_a, 0);
    check("rst_err", err_a, 0);
    reset_n = 1'b1;
    tick();

    // write DEADBEEF to 0x010
    wr_a = 1; addr_a = 12'h010; wdata_a = 32'hDEADBEEF;
    #1;
    check("wr_idle_stall", stall_a, 0);
    tick();
    check("wr_wait_ready", ready_a, 0);
    check("wr_wait_stall", stall_a, 1);
    check("wr_wait_resp", resp_a, 0);
    wr_a = 0;
    tick();
    check("wr_done_resp", resp_a, 1);
    check("wr_done_err", err_a, 0);
    tick();
    check("wr_after_resp", resp_a, 0);
    check("wr_after_ready", ready_a, 1);

    // read 0x010 with request held across WAIT
    rd_a = 1; addr_a = 12'h010;
    tick();
    check("rd_wait_resp", resp_a, 0);
    check("rd_wait_stall", stall_a, 1);
    tick();
    check("rd_done_resp", resp_a, 1);
    check("rd_done_data", rdata_a, 32'hDEADBEEF);
    check("rd_done_stall", stall_a, 1);
    rd_a = 0;
    tick();
    check("rd_idle_resp", resp_a, 0);
    check("rd_hold_data", rdata_a, 32'hDEADBEEF);
    tick();
    check("rd_single_pulse", resp_a, 0);
    check("rd_idle_ready", ready_a, 1);

    // reset during WAIT drops a pending write
    wr_a = 1; addr_a = 12'h040; wdata_a = 32'h11111111;
    tick();
    wr_a = 0;
    tick();
    tick();
    wr_a = 1; wdata_a = 32'h22222222;
    tick();
    check("pre_rst_stall", stall_a, 1);
    reset_n = 1'b0;
    wr_a = 0;
    tick();
    check("mid_rst_ready", ready_a, 1);
    check("mid_rst_resp", resp_a, 0);
    check("mid_rst_rdata", rdata_a, 0);
    reset_n = 1'b1;
    tick();
    rd_a = 1; addr_a = 12'h040;
    tick();
    rd_a = 0;
    tick();
    check("post_rst_resp", resp_a, 1);
    check("post_rst_data", rdata_a, 32'h11111111);
    tick();

    // misaligned read of 0x013
    rd_a = 1; addr_a = 12'h013;
    tick();
    rd_a = 0;
    tick();
    check("mis_resp", resp_a, 1);
    check("mis_err", err_a, ERR_EN ? 32'd1 : 32'd0);
    check("mis_data", rdata_a,
          ERR_EN ? 32'h11111111 : 32'hDEADBEEF);
    tick();

    // simultaneous read+write to 0x020
    wr_a = 1; addr_a = 12'h020; wdata_a = 32'hAAAA0000;
    tick();
    wr_a = 0;
    tick();
    tick();
    rd_a = 1; wr_a = 1; wdata_a = 32'h12345678;
    tick();
    rd_a = 0; wr_a = 0;
    tick();
    check("rw_resp", resp_a, 1);
    check("rw_err", err_a, ERR_EN ? 32'd1 : 32'd0);
    tick();
    rd_a = 1; addr_a = 12'h020;
    tick();
    rd_a = 0;
    tick();
    check("rw_word", rdata_a,
          ERR_EN ? 32'hAAAA0000 : 32'h12345678);
    tick();

    // LATENCY=1: preload 0x000 and 0x004
    wr_b = 1; addr_b = 12'h000; wdata_b = 32'hA0A0A0A0;
    tick();
    check("l1_wr_resp", resp_b, 1);
    addr_b = 12'h004; wdata_b = 32'hB1B1B1B1;
    tick();
    check("l1_wr_idle_resp", resp_b, 0);
    check("l1_wr_idle_ready", ready_b, 1);
    tick();
    check("l1_wr2_resp", resp_b, 1);
    wr_b = 0;
    tick();

    // LATENCY=1 back-to-back reads
    rd_b = 1; addr_b = 12'h000;
    tick();
    check("l1_rd0_resp", resp_b, 1);
    check("l1_rd0_data", rdata_b, 32'hA0A0A0A0);
    check("l1_rd0_stall", stall_b, 1);
    addr_b = 12'h004;
    tick();
    check("l1_gap_resp", resp_b, 0);
    check("l1_gap_stall", stall_b, 0);
    check("l1_gap_ready", ready_b, 1);
    tick();
    check("l1_rd4_resp", resp_b, 1);
    check("l1_rd4_data", rdata_b, 32'hB1B1B1B1);
    rd_b = 0;
    #1;
    check("l1_rd4_stall", stall_b, 0);
    tick();
    check("l1_end_resp", resp_b, 0);
    check("l1_err", err_b, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
